// File: rtl/exe_wb_pkg.sv
// Shared types and constants for the Execute-to-Writeback skid buffer.
// Holds the buffer state encoding (equal to occupancy) and the packet width.
package exe_wb_pkg;

  localparam int unsigned EXE_WB_PKT_W = 96;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skidState_t;

endpackage

// File: rtl/exe_wb_stall_counter.sv
// Saturating event counter; counts cycles where inc_i=1, sticks at all-ones.
// Ports: clk, reset_n (async, active-low), inc_i, cnt_o[CNT_W].
module exe_wb_stall_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exe_wb_skid.sv
// 2-entry skid buffer between Execute and Writeback with valid/ready and flush.
// Ports: clk, reset_n, flush_i, in_valid_i/in_pkt_i/in_ready_o (Execute side),
//   out_valid_o/out_pkt_o/out_ready_i (Writeback side), occupancy_o,
//   stall_cnt_o (only when EXE_WB_STALL_CNT_EN is defined).
module exe_wb_skid
  import exe_wb_pkg::*;
#(
  parameter int unsigned PKT_W = EXE_WB_PKT_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [PKT_W-1:0] in_pkt_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [PKT_W-1:0] out_pkt_o,
  input  logic             out_ready_i,
`ifdef EXE_WB_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
`endif
  output logic [1:0]       occupancy_o
);

  skidState_t       state_q;
  skidState_t       state_d;
  logic [PKT_W-1:0] main_q;
  logic [PKT_W-1:0] main_d;
  logic [PKT_W-1:0] skid_q;
  logic [PKT_W-1:0] skid_d;
  logic             in_ready_q;

  logic accept;
  logic pop;

  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_pkt_o   = main_q;
  assign occupancy_o = state_q;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_pkt_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_pkt_i;
        end else if (accept) begin
          skid_d  = in_pkt_i;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush wins over any same-cycle accept; data is left stale.
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`ifdef EXE_WB_STALL_CNT_EN
  exe_wb_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (out_valid_o & ~out_ready_i),
    .cnt_o   (stall_cnt_o)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (state_q != 2'd3);
      assert (CNT_W > 0);
    end
  end

endmodule

// File: tb/tb_exe_wb_skid.sv
// Self-checking bench for exe_wb_skid: directed steps then random traffic,
// compared against a queue-based reference model.
module tb_exe_wb_skid;
  import exe_wb_pkg::*;

  localparam int PW = 96;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [PW-1:0] in_pkt_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [PW-1:0] out_pkt_o;
  logic          out_ready_i = 1'b0;
  logic [1:0]    occupancy_o;
`ifdef EXE_WB_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_o;
`endif

  exe_wb_skid #(
    .PKT_W (PW),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_pkt_i    (in_pkt_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_pkt_o   (out_pkt_o),
    .out_ready_i (out_ready_i),
`ifdef EXE_WB_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .occupancy_o (occupancy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0]   q[$];
  longint unsigned stall_m = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("occupancy", 128'(occupancy_o), 128'(q.size()));
    chk("out_valid", 128'(out_valid_o), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready_o), 128'(q.size() < 2));
    if (q.size() > 0) chk("out_pkt", 128'(out_pkt_o), 128'(q[0]));
`ifdef EXE_WB_STALL_CNT_EN
    chk("stall_cnt", 128'(stall_cnt_o), 128'(stall_m));
`endif
  endtask

  task automatic cyc(input logic v, input logic [PW-1:0] p,
                     input logic rdy, input logic fl);
    int  n;
    bit  acc;
    bit  pp;
    in_valid_i  = v;
    in_pkt_i    = p;
    out_ready_i = rdy;
    flush_i     = fl;
    @(posedge clk);
    n   = q.size();
    acc = v && (n < 2);
    pp  = (n > 0) && rdy;
    if ((n > 0) && !rdy && (stall_m < 64'hFFFF_FFFF)) stall_m++;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(p);
    if (fl) q.delete();
    #1;
    compare();
  endtask

  initial begin
    logic [PW-1:0] rp;
    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("rst_occ", 128'(occupancy_o), 128'(0));
    chk("rst_out_pkt", 128'(out_pkt_o), 128'(0));
`ifdef EXE_WB_STALL_CNT_EN
    chk("rst_stall", 128'(stall_cnt_o), 128'(0));
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Streaming 0x1..0x8 at full rate
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, PW'(i), 1'b1, 1'b0);
      chk("stream_pkt", 128'(out_pkt_o), 128'(i));
      chk("stream_occ", 128'(occupancy_o), 128'(1));
    end
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: 0xA, 0xB then drain
    cyc(1'b1, PW'(32'hA), 1'b0, 1'b0);
    cyc(1'b1, PW'(32'hB), 1'b0, 1'b0);
    chk("bp_occ", 128'(occupancy_o), 128'(2));
    chk("bp_in_ready", 128'(in_ready_o), 128'(0));
    chk("bp_head", 128'(out_pkt_o), 128'(32'hA));
    // 0xC offered while full is ignored
    cyc(1'b1, PW'(32'hC), 1'b0, 1'b0);
    chk("full_occ", 128'(occupancy_o), 128'(2));
    chk("full_head", 128'(out_pkt_o), 128'(32'hA));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_b", 128'(out_pkt_o), 128'(32'hB));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 128'(out_valid_o), 128'(0));

    // Flush in FULL with concurrent offer of 0xD
    cyc(1'b1, PW'(32'h21), 1'b0, 1'b0);
    cyc(1'b1, PW'(32'h22), 1'b0, 1'b0);
    cyc(1'b1, PW'(32'hD), 1'b0, 1'b1);
    chk("flush_occ", 128'(occupancy_o), 128'(0));
    chk("flush_valid", 128'(out_valid_o), 128'(0));
    chk("flush_ready", 128'(in_ready_o), 128'(1));
    // Flush in ONE drops the same-cycle accept
    cyc(1'b1, PW'(32'h31), 1'b0, 1'b0);
    cyc(1'b1, PW'(32'h32), 1'b1, 1'b1);
    chk("flush1_occ", 128'(occupancy_o), 128'(0));
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Async reset while holding 0xE
    cyc(1'b1, PW'(32'hE), 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid_o), 128'(0));
    chk("arst_pkt", 128'(out_pkt_o), 128'(0));
    chk("arst_occ", 128'(occupancy_o), 128'(0));
    chk("arst_ready", 128'(in_ready_o), 128'(1));
    q.delete();
    stall_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Stall run: 5 stalled cycles, then flush with a pop
    cyc(1'b1, PW'(32'h41), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef EXE_WB_STALL_CNT_EN
    chk("stall_5", 128'(stall_cnt_o), 128'(5));
`endif
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
`ifdef EXE_WB_STALL_CNT_EN
    chk("stall_after_flush", 128'(stall_cnt_o), 128'(5));
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rp = {$urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), rp,
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_wb_skid.md
Name: exe_wb_skid

Overview:
- Pipeline buffer between the Execute stage output and the Writeback/bypass stage. It is the receive-side counterpart of the RegRead-to-Execute register.
- Accepts one result packet per cycle from Execute and presents it to Writeback with a valid/ready handshake.
- A 2-entry skid (main + skid register) absorbs one cycle of Writeback backpressure at full throughput.
- Flush discards all buffered packets.

Parameters:
- PKT_W, 96, width of the opaque result packet (dest tag, data, flags); valid is carried separately.
- CNT_W, 32, width of the optional stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous kill of all buffered and incoming packets.
- in_valid_i  in  1  Execute presents a packet.
- in_pkt_i  in  PKT_W  packet from Execute.
- in_ready_o  out  1  buffer can accept; registered (no combinational path from out_ready_i).
- out_valid_o  out  1  packet available to Writeback.
- out_pkt_o  out  PKT_W  head packet, driven from the main register.
- out_ready_i  in  1  Writeback consumes the head this cycle when out_valid_o=1.
- occupancy_o  out  2  entries held (0..2).
- stall_cnt_o  out  CNT_W  present only with EXE_WB_STALL_CNT_EN.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=EMPTY; out_valid_o=0; in_ready_o=1; occupancy_o=0.
  - out_pkt_o=0; skid data=0; stall_cnt_o=0.
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Pop = out_valid_o & out_ready_i.
  - Packet data only moves on accept or pop; it never changes while out_valid_o=1 and out_ready_i=0.
- States (occupancy_o encodes the state):
  - EMPTY: out_valid_o=0, in_ready_o=1. Accept: main<=in, go to ONE.
  - ONE: out_valid_o=1, in_ready_o=1.
    - Accept and pop: main<=in, stay ONE.
    - Accept, no pop: skid<=in, go to FULL.
    - Pop, no accept: go to EMPTY.
    - Neither: hold.
  - FULL: out_valid_o=1, in_ready_o=0.
    - Pop: main<=skid, go to ONE.
    - No pop: hold.
    - in_valid_i is ignored while in_ready_o=0.
- Latency: a packet accepted in cycle N appears on out_valid_o/out_pkt_o in cycle N+1 at the earliest.
- Throughput: one packet per cycle sustained when out_ready_i stays 1.
- Order: strict FIFO; the skid entry is never presented before the main entry.
- in_ready_o is a registered copy of (next_state != FULL).
- Flush:
  - Next state is EMPTY regardless of accept or pop in the same cycle.
  - A packet accepted in the flush cycle is dropped.
  - A pop in the flush cycle still counts as delivered to Writeback; Writeback qualifies with flush itself.
  - Data registers need not be cleared.
- Reset asserted mid-transfer aborts the transfer immediately; no packet survives.
- occupancy_o is never 3; an assertion in simulation checks this.

Optional Feature:
- Macro: EXE_WB_STALL_CNT_EN.
- Defined:
  - stall_cnt_o increments on each cycle with out_valid_o=1 and out_ready_i=0.
  - It saturates at all-ones and is cleared only by reset (not by flush).
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package exe_wb_pkg holds:
  - typedef enum logic [1:0] {EMPTY=0, ONE=1, FULL=2} skidState_t;
  - constant EXE_WB_PKT_W=96.
- One sub-module is natural: exe_wb_stall_counter (saturating counter, CNT_W param), instantiated only under the macro.

Test Plan:
- Streaming: out_ready_i=1, in_valid_i=1 for 8 cycles, pkts 0x1..0x8 -> out_pkt_o shows 0x1..0x8 on cycles 1..8; occupancy_o stays 1; in_ready_o stays 1.
- Backpressure: push 0xA then 0xB with out_ready_i=0 -> occupancy_o=2, in_ready_o=0 next cycle, out_pkt_o holds 0xA. Then out_ready_i=1 -> 0xA, then 0xB popped in order.
- Full-state input ignored: in FULL, drive in_valid_i=1 with 0xC -> 0xC is never output; occupancy_o stays 2.
- Flush: in FULL, flush_i=1 together with in_valid_i=1 (0xD) -> next cycle occupancy_o=0, out_valid_o=0, in_ready_o=1; 0xD is never output.
- Async reset: in ONE holding 0xE, pulse reset_n low mid-cycle -> out_valid_o=0 and out_pkt_o=0 immediately, before the next clock edge.
- Stall counter (macro on): hold out_valid_o=1 with out_ready_i=0 for 5 cycles -> stall_cnt_o=5. Flush, then check -> stall_cnt_o still 5.
